// File: rtl/uart_cmd_parser.sv
// +-----------------------------------------------------------------------------+
// | uart_cmd_parser: framed read/write register-access parser between the UART |
// | FIFOs and a simple register bus. Optional macro: CMD_TIMEOUT_EN.           |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module uart_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter logic [7:0] ACK_BYTE       = 8'h06,
  parameter logic [7:0] NAK_BYTE       = 8'h15,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  input  logic       tx_full,
  output logic [7:0] w_data,
  output logic       wr_uart,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata
);

  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_DATA   = 3'd3,
    S_CHK    = 3'd4,
    S_EXEC   = 3'd5,
    S_RDWAIT = 3'd6,
    S_RESP   = 3'd7
  } state_t;

  state_t     state;
  logic [7:0] cmd;
  logic [7:0] addr;
  logic [7:0] data;
  logic [7:0] resp_next;
  logic       resp_two;
  logic       rx_state;
  logic       in_frame;
  logic       take;
  logic       push;
  logic       timed_out;
  logic [7:0] chk_exp;

  assign rx_state = (state == S_IDLE) || (state == S_CMD) || (state == S_ADDR) ||
                    (state == S_DATA) || (state == S_CHK);
  assign in_frame = rx_state && (state != S_IDLE);

  // FIFO handshakes are decoded from state so a pop/push lands in the same cycle
  // the byte is captured/offered; gating with reset keeps them low during reset.
  assign take    = reset && rx_state && !rx_empty;
  assign push    = reset && (state == S_RESP) && !tx_full;
  assign rd_uart = take;
  assign wr_uart = push;

  assign chk_exp = cmd ^ addr ^ ((cmd == CMD_WR) ? data : 8'h00);

`ifdef CMD_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;

  assign timed_out = in_frame && !take && (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (!in_frame || take || timed_out) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cmd       <= 8'h00;
      addr      <= 8'h00;
      data      <= 8'h00;
      resp_next <= 8'h00;
      resp_two  <= 1'b0;
      w_data    <= 8'h00;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      if (timed_out) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (take && (r_data == SYNC_BYTE)) state <= S_CMD;
          end
          S_CMD: begin
            if (take) begin
              cmd <= r_data;
              if ((r_data == CMD_WR) || (r_data == CMD_RD)) begin
                state <= S_ADDR;
              end else begin
                w_data   <= NAK_BYTE;
                resp_two <= 1'b0;
                state    <= S_RESP;
              end
            end
          end
          S_ADDR: begin
            if (take) begin
              addr  <= r_data;
              state <= (cmd == CMD_WR) ? S_DATA : S_CHK;
            end
          end
          S_DATA: begin
            if (take) begin
              data  <= r_data;
              state <= S_CHK;
            end
          end
          S_CHK: begin
            if (take) begin
              if (r_data == chk_exp) begin
                reg_addr <= addr;
                if (cmd == CMD_WR) begin
                  reg_wdata <= data;
                  reg_we    <= 1'b1;
                end else begin
                  reg_re <= 1'b1;
                end
                state <= S_EXEC;
              end else begin
                w_data   <= NAK_BYTE;
                resp_two <= 1'b0;
                state    <= S_RESP;
              end
            end
          end
          S_EXEC: begin
            if (cmd == CMD_WR) begin
              w_data   <= ACK_BYTE;
              resp_two <= 1'b0;
              state    <= S_RESP;
            end else begin
              state <= S_RDWAIT;
            end
          end
          S_RDWAIT: begin
            w_data    <= ACK_BYTE;
            resp_next <= reg_rdata;
            resp_two  <= 1'b1;
            state     <= S_RESP;
          end
          S_RESP: begin
            if (push) begin
              if (resp_two) begin
                w_data   <= resp_next;
                resp_two <= 1'b0;
              end else begin
                state <= S_IDLE;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: FIFO and register-bus models with scoreboards for
// TX bytes and bus accesses, table-driven frames plus multi-cycle corner cases.
`timescale 1ns/1ps
`default_nettype none

module tb_uart_cmd_parser;

  localparam int TB_TO = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       tx_full = 1'b0;
  logic [7:0] reg_rdata = 8'h00;
  logic       rd_uart, wr_uart, reg_we, reg_re;
  logic [7:0] w_data, reg_addr, reg_wdata;

  uart_cmd_parser #(.TIMEOUT_CYCLES(TB_TO)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } bus_t;

  typedef struct {
    int          len;
    logic [63:0] frame;
    int          nresp;
    logic [15:0] resp;
    logic        has_bus;
    bus_t        bus;
  } vec_t;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [7:0] rxq[$];
  logic [7:0] exp_tx[$];
  bus_t       exp_bus[$];
  int         pop_log[$];
  int         tx_log[$];
  int         bus_log[$];
  logic [7:0] mem[256];
  logic       do_pop = 1'b0, do_we = 1'b0, do_re = 1'b0;
  logic [7:0] s_addr = 8'h00, s_wdata = 8'h00;
  vec_t       vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic upd_rx();
    rx_empty = (rxq.size() == 0);
    r_data   = rx_empty ? 8'h00 : rxq[0];
  endtask

  // Observe DUT outputs mid-cycle; the transfers they request take effect at the next edge.
  always @(negedge clk) begin
    bus_t e;
    cyc++;
    do_pop = rd_uart; do_we = reg_we; do_re = reg_re;
    s_addr = reg_addr; s_wdata = reg_wdata;
    check("rd_while_empty", {31'd0, rd_uart & rx_empty}, 0);
    check("we_re_overlap", {31'd0, reg_we & reg_re}, 0);
    check("wr_while_full", {31'd0, wr_uart & tx_full}, 0);
    if (rd_uart) pop_log.push_back(cyc);
    if (wr_uart) begin
      tx_log.push_back(cyc);
      if (exp_tx.size() == 0) check("tx_unexpected", {24'd0, w_data}, 32'h100);
      else check("tx_byte", {24'd0, w_data}, {24'd0, exp_tx.pop_front()});
    end
    if (reg_we || reg_re) begin
      bus_log.push_back(cyc);
      if (exp_bus.size() == 0) begin
        check("bus_unexpected", {31'd0, reg_we | reg_re}, 0);
      end else begin
        e = exp_bus.pop_front();
        check("bus_kind_we", {31'd0, reg_we}, {31'd0, e.we});
        check("bus_addr", {24'd0, reg_addr}, {24'd0, e.addr});
        if (e.we) check("bus_wdata", {24'd0, reg_wdata}, {24'd0, e.data});
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (do_pop && rxq.size() > 0) void'(rxq.pop_front());
    upd_rx();
    if (do_we) mem[s_addr] = s_wdata;
    if (do_re) reg_rdata = mem[s_addr];
    do_pop = 1'b0; do_we = 1'b0; do_re = 1'b0;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [63:0] frame, input int len);
    for (int j = 0; j < len; j++) rxq.push_back(frame[63-8*j -: 8]);
    upd_rx();
  endtask

  task automatic run(input string name, input int budget);
    int k = 0;
    while ((rxq.size() + exp_tx.size() + exp_bus.size()) != 0 && k < budget) begin
      tick(1);
      k++;
    end
    tick(4);
    check(name, rxq.size() + exp_tx.size() + exp_bus.size(), 0);
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {rd_uart, wr_uart, reg_we, reg_re, w_data, reg_addr, reg_wdata}, 0);
  endtask

  function automatic vec_t mk(input int len, input logic [63:0] f, input int nr,
                              input logic [15:0] r, input logic hb, input logic we,
                              input logic [7:0] a, input logic [7:0] d);
    vec_t v;
    v.len = len; v.frame = f; v.nresp = nr; v.resp = r;
    v.has_bus = hb; v.bus = '{we: we, addr: a, data: d};
    return v;
  endfunction

  initial begin
    int pl;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    upd_rx();

    vecs[0] = mk(5, 64'hA501103C2D000000, 1, 16'h0600, 1, 1, 8'h10, 8'h3C);
    vecs[1] = mk(4, 64'hA502101200000000, 2, 16'h063C, 1, 0, 8'h10, 8'h00);
    vecs[2] = mk(5, 64'hA501103C00000000, 1, 16'h1500, 0, 0, 8'h00, 8'h00);
    vecs[3] = mk(4, 64'h00FFA50700000000, 1, 16'h1500, 0, 0, 8'h00, 8'h00);
    vecs[4] = mk(5, 64'hA501205574000000, 1, 16'h0600, 1, 1, 8'h20, 8'h55);
    vecs[5] = mk(4, 64'hA502202200000000, 2, 16'h0655, 1, 0, 8'h20, 8'h00);
    vecs[6] = mk(4, 64'hA502200000000000, 1, 16'h1500, 0, 0, 8'h00, 8'h00);
    vecs[7] = mk(7, 64'hA503A501307E4F00, 2, 16'h1506, 1, 1, 8'h30, 8'h7E);
    vecs[8] = mk(5, 64'hA501FF00FE000000, 1, 16'h0600, 1, 1, 8'hFF, 8'h00);
    vecs[9] = mk(4, 64'hA502FFFD00000000, 2, 16'h0600, 1, 0, 8'hFF, 8'h00);

    tick(3);
    check_outputs_zero("reset_outputs");
    reset = 1'b1;
    tick(2);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].has_bus) exp_bus.push_back(vecs[i].bus);
      for (int j = 0; j < vecs[i].nresp; j++) exp_tx.push_back(vecs[i].resp[15-8*j -: 8]);
      send(vecs[i].frame, vecs[i].len);
      run($sformatf("vec%0d_done", i), 200);
    end

    // Latency from the checksum pop to strobe and response pushes.
    pop_log.delete(); tx_log.delete(); bus_log.delete();
    exp_bus.push_back('{we: 1'b1, addr: 8'h40, data: 8'h99});
    exp_tx.push_back(8'h06);
    send(64'hA5014099D8000000, 5);
    run("lat_wr_done", 100);
    pl = pop_log.size() > 0 ? pop_log[$] : 0;
    check("lat_wr_strobe", bus_log.size() > 0 ? bus_log[0] - pl : -1, 1);
    check("lat_wr_ack", tx_log.size() > 0 ? tx_log[0] - pl : -1, 2);

    pop_log.delete(); tx_log.delete(); bus_log.delete();
    exp_bus.push_back('{we: 1'b0, addr: 8'h40, data: 8'h00});
    exp_tx.push_back(8'h06); exp_tx.push_back(8'h99);
    send(64'hA502404200000000, 4);
    run("lat_rd_done", 100);
    pl = pop_log.size() > 0 ? pop_log[$] : 0;
    check("lat_rd_strobe", bus_log.size() > 0 ? bus_log[0] - pl : -1, 1);
    check("lat_rd_ack", tx_log.size() > 0 ? tx_log[0] - pl : -1, 3);
    check("lat_rd_data", tx_log.size() > 1 ? tx_log[1] - pl : -1, 4);

    // Back-pressure: response waits on tx_full, next frame stays in the RX FIFO.
    tx_log.delete();
    tx_full = 1'b1;
    exp_bus.push_back('{we: 1'b0, addr: 8'h10, data: 8'h00});
    exp_bus.push_back('{we: 1'b1, addr: 8'h11, data: 8'h22});
    exp_tx.push_back(8'h06); exp_tx.push_back(8'h3C); exp_tx.push_back(8'h06);
    send(64'hA502101200000000, 4);
    tick(10);
    send(64'hA501112232000000, 5);
    tick(20);
    check("full_no_push", tx_log.size(), 0);
    check("rx_held_in_resp", rxq.size(), 5);
    tx_full = 1'b0;
    run("backpressure_done", 100);

    // Reset mid-frame clears outputs asynchronously; a new frame then works.
    send(64'hA501000000000000, 2);
    tick(4);
    #1 reset = 1'b0;
    #1 check_outputs_zero("midframe_reset_outputs");
    tick(2);
    reset = 1'b1;
    tick(2);
    exp_bus.push_back('{we: 1'b1, addr: 8'h10, data: 8'h3C});
    exp_tx.push_back(8'h06);
    send(64'hA501103C2D000000, 5);
    run("after_reset_done", 100);

    // Reset mid-response drops the unsent bytes.
    tx_full = 1'b1;
    exp_bus.push_back('{we: 1'b0, addr: 8'h10, data: 8'h00});
    send(64'hA502101200000000, 4);
    tick(15);
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tx_full = 1'b0;
    tick(10);
    check("resp_reset_bus_done", exp_bus.size(), 0);

    // Abandoned frame followed by a full read frame.
    send(64'hA501000000000000, 2);
    tick(2 * TB_TO + 10);
`ifdef CMD_TIMEOUT_EN
    exp_bus.push_back('{we: 1'b0, addr: 8'h10, data: 8'h00});
    exp_tx.push_back(8'h06); exp_tx.push_back(8'h3C);
`else
    exp_tx.push_back(8'h15);
`endif
    send(64'hA502101200000000, 4);
    run("timeout_done", 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
